// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC core: fetch FSM states, opcodes, branch
// condition codes and flag bit positions.
package wisc_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Opcodes live in instr[15:12]; the control decoder uses the same table.
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    // Branch condition codes, instr[11:9].
    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    // Flag vector is packed {Z,V,N}.
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    // Word offset of a B instruction turned into a byte offset.
    function automatic logic [15:0] branch_offset(input logic [8:0] imm);
        return {{6{imm[8]}}, imm, 1'b0};
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluator: selects the condition named by
// ccc and tests it against the {Z,V,N} flags.
module branch_cond
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       cond
);

    logic w_z;
    logic w_v;
    logic w_n;

    assign w_z = flags[FLAG_Z];
    assign w_v = flags[FLAG_V];
    assign w_n = flags[FLAG_N];

    always_comb begin
        // NOTE: default first so every path assigns cond; otherwise a latch is inferred.
        cond = 1'b0;
        case (ccc)
            CC_NE:   cond = !w_z;
            CC_EQ:   cond = w_z;
            CC_GT:   cond = !w_z && !w_n;
            CC_LT:   cond = w_n;
            CC_GE:   cond = w_z || !w_n;
            CC_LE:   cond = w_z || w_n;
            CC_OV:   cond = w_v;
            CC_UNC:  cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch/PC stage of the WISC core: PC and flag registers, instruction fetch
// handshake, next-PC resolution and HLT handling.
module fetch_pc_unit
    import wisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_req,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    input  logic        branch,
    input  logic        jump_reg,
    input  logic        hlt,
    input  logic [15:0] rs_data,
    input  logic [2:0]  flag_en,
    input  logic [2:0]  flags_in,
    output logic [2:0]  flags,
    output logic        halted
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [2:0]  r_flags;

    logic [15:0] w_pc_plus2;
    logic [15:0] w_branch_target;
    logic [15:0] w_pc_next;
    logic [2:0]  w_flags_next;
    logic        w_cond;
    logic        w_fetch_done;
    logic        w_commit;

    // Both adders wrap modulo 2^16; target bit 0 is deliberately not masked.
    assign w_pc_plus2      = r_pc + 16'd2;
    assign w_branch_target = w_pc_plus2 + branch_offset(r_instr[8:0]);

    branch_cond u_branch_cond (
        .ccc   (r_instr[11:9]),
        .flags (r_flags),
        .cond  (w_cond)
    );

    always_comb begin
        w_pc_next = w_pc_plus2;
        if (hlt) begin
            w_pc_next = r_pc;
        end else if (branch && w_cond) begin
            w_pc_next = jump_reg ? rs_data : w_branch_target;
        end
    end

    // Condition evaluation above reads r_flags, so a coinciding flag write
    // is seen only by the next instruction.
    assign w_flags_next = (r_flags & ~flag_en) | (flags_in & flag_en);

    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        w_fetch_done = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    w_fetch_done = 1'b1;
                    w_state_next = EXEC;
                end
            end
            EXEC: begin
                instr_valid  = 1'b1;
                w_commit     = 1'b1;
                w_state_next = hlt ? HALT : FETCH;
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use <= so every flop samples pre-edge values.
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= 16'h0000;
        end else if (w_fetch_done) begin
            r_instr <= imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_flags <= 3'b000;
        end else if (w_commit) begin
            r_pc    <= w_pc_next;
            r_flags <= w_flags_next;
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_plus2  = w_pc_plus2;
    assign instr     = r_instr;
    assign flags     = r_flags;
    assign halted    = (r_state == HALT);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: expected fetch addresses are queued
// when each instruction commits and compared when the next fetch starts.
module tb_fetch_pc_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        branch;
    logic        jump_reg;
    logic        hlt;
    logic [15:0] rs_data;
    logic [2:0]  flag_en;
    logic [2:0]  flags_in;
    logic [2:0]  flags;
    logic        halted;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus2    (pc_plus2),
        .branch      (branch),
        .jump_reg    (jump_reg),
        .hlt         (hlt),
        .rs_data     (rs_data),
        .flag_en     (flag_en),
        .flags_in    (flags_in),
        .flags       (flags),
        .halted      (halted)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_addr_q[$];
    logic [15:0] m_pc;
    logic [2:0]  m_flags;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        branch     = 1'b0;
        jump_reg   = 1'b0;
        hlt        = 1'b0;
        rs_data    = 16'h0000;
        flag_en    = 3'b000;
        flags_in   = 3'b000;
    endtask

    // Reference condition table, flags packed {Z,V,N}.
    function automatic logic model_cond(input logic [2:0] ccc, input logic [2:0] f);
        logic z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (ccc)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return z || n;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_checks++;
        if (pc !== RESET_PC || instr !== 16'h0000 || flags !== 3'b000 ||
            halted !== 1'b0 || instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: pc=%h instr=%h flags=%b halted=%b iv=%b, expected pc=%h instr=0000 flags=000 halted=0 iv=0",
                     pc, instr, flags, halted, instr_valid, RESET_PC);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            n_errors++;
            $display("FAIL reset_release: imem_req=%b imem_addr=%h, expected 1 and %h",
                     imem_req, imem_addr, RESET_PC);
        end
        m_pc    = RESET_PC;
        m_flags = 3'b000;
        exp_addr_q.delete();
        exp_addr_q.push_back(RESET_PC);
    endtask

    // Fetch one instruction after 'waits' stall cycles, then commit it with
    // the given decoder strobes. Starts and ends inside a FETCH cycle.
    task automatic run_instr(input string name, input logic [15:0] word, input int waits,
                             input logic br, input logic jr, input logic h,
                             input logic [15:0] rs, input logic [2:0] fen, input logic [2:0] fin);
        logic [15:0] exp_addr;
        logic [15:0] nxt;
        int          soff;
        int          pulses;
        pulses = 0;
        if (exp_addr_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard: no expected fetch address queued", name);
            exp_addr = m_pc;
        end else begin
            exp_addr = exp_addr_q.pop_front();
        end

        for (int i = 0; i <= waits; i++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                n_errors++;
                $display("FAIL %s fetch[%0d]: imem_req=%b imem_addr=%h, expected 1 and %h",
                         name, i, imem_req, imem_addr, exp_addr);
            end
            if (instr_valid === 1'b1) pulses++;
            // Decoder strobes carry junk during FETCH; they must be ignored.
            branch     = 1'b1;
            jump_reg   = 1'b1;
            hlt        = 1'b1;
            rs_data    = 16'hFFFF;
            flag_en    = 3'b111;
            flags_in   = ~m_flags;
            imem_valid = (i == waits);
            imem_rdata = (i == waits) ? word : (16'hA5A5 ^ 16'(i));
            tick();
        end

        n_checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== word || pc !== m_pc ||
            pc_plus2 !== 16'(m_pc + 16'd2) || flags !== m_flags || halted !== 1'b0) begin
            n_errors++;
            $display("FAIL %s exec: iv=%b req=%b instr=%h pc=%h pc+2=%h flags=%b halted=%b, expected 1 0 %h %h %h %b 0",
                     name, instr_valid, imem_req, instr, pc, pc_plus2, flags, halted,
                     word, m_pc, 16'(m_pc + 16'd2), m_flags);
        end
        if (instr_valid === 1'b1) pulses++;

        branch     = br;
        jump_reg   = jr;
        hlt        = h;
        rs_data    = rs;
        flag_en    = fen;
        flags_in   = fin;
        imem_valid = 1'b1;
        imem_rdata = ~word;

        soff = int'($signed(word[8:0]));
        if (h) nxt = m_pc;
        else if (br && model_cond(word[11:9], m_flags)) nxt = jr ? rs : 16'(int'(m_pc) + 2 + 2 * soff);
        else nxt = 16'(int'(m_pc) + 2);
        for (int b = 0; b < 3; b++) begin
            if (fen[b]) m_flags[b] = fin[b];
        end
        m_pc = nxt;
        if (!h) exp_addr_q.push_back(nxt);

        tick();
        idle_inputs();

        if (h) begin
            n_checks++;
            if (halted !== 1'b1 || pc !== m_pc || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL %s halt_entry: halted=%b pc=%h req=%b iv=%b, expected 1 %h 0 0",
                         name, halted, pc, imem_req, instr_valid, m_pc);
            end
        end else begin
            n_checks++;
            if (instr_valid !== 1'b0 || pulses != 1 || flags !== m_flags) begin
                n_errors++;
                $display("FAIL %s commit: iv_after=%b pulses=%0d flags=%b, expected 0 1 %b",
                         name, instr_valid, pulses, flags, m_flags);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_sequential();
        run_instr("seq0", 16'h0000, 0, 1'b0, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
        run_instr("seq1", 16'h0000, 0, 1'b0, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
        run_instr("seq2", 16'h0000, 0, 1'b0, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
    endtask

    task automatic test_branch_cond();
        // Jump to 0x0010 and set Z; B EQ +2 words then lands on 0x0016.
        run_instr("br_to_10_z1", 16'hDE30, 0, 1'b1, 1'b1, 1'b0, 16'h0010, 3'b100, 3'b100);
        run_instr("beq_taken", 16'hC202, 0, 1'b1, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
        run_instr("br_to_10_z0", 16'hDE30, 0, 1'b1, 1'b1, 1'b0, 16'h0010, 3'b100, 3'b000);
        run_instr("beq_not_taken", 16'hC202, 0, 1'b1, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
        // Branch and flag write in the same commit: old Z=1 still decides.
        run_instr("br_to_10_z1b", 16'hDE30, 0, 1'b1, 1'b1, 1'b0, 16'h0010, 3'b100, 3'b100);
        run_instr("beq_old_flags", 16'hC202, 0, 1'b1, 1'b0, 1'b0, 16'h0, 3'b100, 3'b000);
        run_instr("beq_new_flags", 16'hC202, 0, 1'b1, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
        for (int k = 0; k < 16; k++) begin
            logic [2:0]  ccc;
            logic [2:0]  fl;
            logic [15:0] w;
            ccc = 3'(k);
            fl  = 3'($urandom_range(0, 7));
            w   = {4'hC, ccc, 9'h004};
            run_instr("set_flags", 16'h0000, 0, 1'b0, 1'b0, 1'b0, 16'h0, 3'b111, fl);
            run_instr("b_cond_sweep", w, 0, 1'b1, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
        end
    endtask

    task automatic test_jump();
        run_instr("br_1234", 16'hDE30, 0, 1'b1, 1'b1, 1'b0, 16'h1234, 3'b000, 3'b000);
        run_instr("br_0000", 16'hDE30, 0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'b000, 3'b000);
        run_instr("b_unc_self", 16'hCFFF, 0, 1'b1, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
        run_instr("br_fffe", 16'hDE30, 0, 1'b1, 1'b1, 1'b0, 16'hFFFE, 3'b000, 3'b000);
        run_instr("add_wrap", 16'h0000, 0, 1'b0, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
        run_instr("br_odd", 16'hDE30, 0, 1'b1, 1'b1, 1'b0, 16'h0101, 3'b100, 3'b100);
        // BR NE with Z=1 falls through instead of jumping.
        run_instr("br_ne_not_taken", 16'hD030, 0, 1'b1, 1'b1, 1'b0, 16'h4000, 3'b000, 3'b000);
    endtask

    task automatic test_wait_states();
        run_instr("wait3", 16'h1234, 3, 1'b0, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
        run_instr("wait1", 16'h0000, 1, 1'b0, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
    endtask

    task automatic test_halt();
        run_instr("br_to_8", 16'hDE30, 0, 1'b1, 1'b1, 1'b0, 16'h0008, 3'b000, 3'b000);
        run_instr("hlt", 16'hF000, 0, 1'b0, 1'b0, 1'b1, 16'h0, 3'b000, 3'b000);
        for (int i = 0; i < 20; i++) begin
            imem_valid = 1'b1;
            imem_rdata = 16'h5555;
            branch     = 1'b1;
            jump_reg   = 1'b1;
            rs_data    = 16'h7777;
            flag_en    = 3'b111;
            flags_in   = ~m_flags;
            tick();
            n_checks++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 ||
                pc !== 16'h0008 || flags !== m_flags || instr !== 16'hF000) begin
                n_errors++;
                $display("FAIL halt_hold[%0d]: halted=%b req=%b iv=%b pc=%h flags=%b instr=%h, expected 1 0 0 0008 %b F000",
                         i, halted, imem_req, instr_valid, pc, flags, instr, m_flags);
            end
        end
        apply_reset();
        run_instr("restart_after_halt", 16'h0000, 0, 1'b0, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
    endtask

    task automatic test_reset_mid_fetch();
        run_instr("pre_reset", 16'h2468, 0, 1'b0, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
        imem_valid = 1'b0;
        tick();
        rst        = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 16'hBEEF;
        tick();
        n_checks++;
        if (instr !== 16'h0000 || instr_valid !== 1'b0 || pc !== RESET_PC || imem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_fetch: instr=%h iv=%b pc=%h req=%b, expected 0000 0 %h 1",
                     instr, instr_valid, pc, imem_req, RESET_PC);
        end
        rst        = 1'b0;
        imem_valid = 1'b0;
        tick();
        n_checks++;
        if (instr !== 16'h0000 || instr_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            n_errors++;
            $display("FAIL reset_release_idle: instr=%h iv=%b addr=%h, expected 0000 0 %h",
                     instr, instr_valid, imem_addr, RESET_PC);
        end
        m_pc    = RESET_PC;
        m_flags = 3'b000;
        exp_addr_q.delete();
        exp_addr_q.push_back(RESET_PC);
        run_instr("restart_after_abort", 16'h0000, 0, 1'b0, 1'b0, 1'b0, 16'h0, 3'b000, 3'b000);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_cond();
        test_jump();
        test_wait_states();
        test_halt();
        test_reset_mid_fetch();
        n_checks++;
        if (exp_addr_q.size() != 1) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 1", exp_addr_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
